dispatch_issue_sched: RTL and testbench
=======================================

# dispatch_issue_sched

In-order issue scheduler between rename and the seven reservation stations (Alu1, Alu2, Bru, Csru, Div, Mul, Lsu). Each cycle it decides which ways of the 4-wide decode group dispatch, binds each dispatching way to one RS write port, and checks ROB and free-list capacity. It tracks partially dispatched groups across cycles and holds the decode stage until the whole group has left.

## Interface
- WAYS, 4, group width; fixed, not swept
- CNT_W, 7, width of capacity counts
- Clk  in  1  clock, rising edge
- Rest  in  1  reset, asynchronous, active-low
- DispatchFlash  in  1  pipeline flush; kills the pending group
- GroupValid  in  1  decode group present and held stable while DispatchStop=1
- WayValid  in  4  per-way instruction valid
- WayClass  in  12  3 bits per way (way0 = [2:0]): 0 ALU, 1 BRU, 2 CSRU, 3 DIV, 4 MUL, 5 LSU, 6/7 ROB-only (no RS)
- WayWrite  in  4  way needs a physical destination register
- RsFull  in  7  bit0 Alu1, 1 Alu2, 2 Bru, 3 Csru, 4 Div, 5 Mul, 6 Lsu
- RobFreeNumb  in  CNT_W  free ROB entries
- FreeRegNumb  in  CNT_W  free physical registers
- WayFire  out  4  way dispatches this cycle
- RsPush  out  7  RS write strobe, same bit order as RsFull
- RsWaySel  out  14  2-bit source-way index per RS (RS k = [2k+1:2k])
- DispatchStop  out  1  decode must hold its group next cycle
- StallCycles  out  8  saturating count of zero-progress cycles

## Operation
- Registered state:
  - DoneMask[3:0]: ways of the current group that have already fired.
  - AluRr: ALU preference bit. 0 = Alu1 first.
  - StallCycles.
- Pending ways = WayValid & ~DoneMask, considered only when GroupValid=1.
- Ways are evaluated in order 0→3. Way i may fire only if every lower pending way also fires this cycle, so nothing dispatches out of order.
- Per-way RS binding:
  - Classes 1–5 need their RS to be not full and not already claimed by a lower way this cycle.
  - ALU takes the preferred ALU RS if it is free and unclaimed, otherwise the other ALU RS. This allows at most 2 ALU ways per cycle.
  - Classes 6/7 need no RS.
- Capacity checks, applied to the fire prefix only:
  - Number of firing ways ≤ RobFreeNumb.
  - Number of firing ways with WayWrite=1 ≤ FreeRegNumb.
- RsPush[k] = 1 and RsWaySel[k] = way index when way claims RS k; otherwise RsWaySel[k] = 0.
- DispatchStop = GroupValid & ~DispatchFlash & (pending & ~WayFire ≠ 0).
- DoneMask next:
  - Clears to 0 if DispatchFlash, or if GroupValid and all pending ways fire (group complete).
  - Otherwise becomes DoneMask | WayFire.
- AluRr toggles when exactly one ALU way fires; unchanged otherwise.
- StallCycles increments, saturating at 255, when GroupValid=1, pending≠0, WayFire=0 and no flush. It never clears except on reset (perf counter).
- DispatchFlash has priority over everything:
  - WayFire, RsPush and DispatchStop are 0 that cycle.
  - DoneMask clears. AluRr and StallCycles are unchanged.
- GroupValid=0: all strobes 0 and DispatchStop=0.

## Timing
- Reset (Rest=0, asynchronous):
  - DoneMask=0, AluRr=0, StallCycles=0.
  - All combinational outputs are forced 0: WayFire, RsPush, RsWaySel, DispatchStop.
- Release of reset is synchronised externally; the first evaluation is in the cycle after Rest rises.
- WayFire, RsPush, RsWaySel and DispatchStop are combinational from inputs and registered state. They are valid in the same cycle as GroupValid, and downstream captures them on the same rising edge.
- State updates on the rising edge of Clk.
- Groups:
  - A fully dispatchable group completes in 1 cycle.
  - A group blocked at way i resumes from way i in the next cycle, with no re-issue of done ways.
- Boundary cases:
  - RobFreeNumb=0 or all needed RS full: zero progress, DispatchStop=1, StallCycles increments.
  - RobFreeNumb ≥ 127 is never a limit.
  - WayValid=0 with GroupValid=1 completes immediately: DispatchStop=0, no strobes.
  - Reset asserted mid-group drops DoneMask; decode re-presents the group from way 0.

## Test plan
- 4 ways of classes ALU, BRU, LSU, MUL; no RS full; RobFree=10; FreeReg=10 → WayFire=1111, RsPush=1100101, RsWaySel Alu1=0, Bru=1, Lsu=2, Mul=3, DispatchStop=0.
- 3 ALU ways + 1 LSU, AluRr=0 → cycle 1: WayFire=0011 with Alu1←way0, Alu2←way1, DispatchStop=1. Cycle 2 (same group): WayFire=1100, DispatchStop=0, DoneMask returns to 0.
- 4 DIV-free ways with RobFreeNumb=2 → WayFire=0011, DispatchStop=1. Next cycle with RobFreeNumb=5 → WayFire=1100.
- Way0 DIV with RsFull[4]=1 held for 300 cycles, way1 ALU → WayFire=0000 throughout, StallCycles saturates at 255. Then clearing RsFull → WayFire=0011.
- Partial group (DoneMask=0011) with DispatchFlash=1 → all strobes 0, DispatchStop=0. The next group is evaluated from way 0.
- Single ALU way on alternating cycles → Alu1, Alu2, Alu1 chosen in turn. When Alu1 is full, Alu2 is taken regardless of AluRr.

Source files
------------

// File: rtl/dispatch_issue_sched_if.sv
// Dispatch bus between decode/rename and the issue scheduler.
// Outputs suffixed _c are combinational and are captured downstream on the same edge.
interface dispatch_issue_sched_if #(
  parameter int unsigned WAYS   = 4,
  parameter int unsigned CNT_W  = 7,
  parameter int unsigned NUM_RS = 7
);
  // decode / rename side
  logic                  dispatch_flash;
  logic                  group_valid;
  logic [WAYS-1:0]       way_valid;
  logic [3*WAYS-1:0]     way_class;
  logic [WAYS-1:0]       way_write;
  // reservation station / capacity status
  logic [NUM_RS-1:0]     rs_full;
  logic [CNT_W-1:0]      rob_free_numb;
  logic [CNT_W-1:0]      free_reg_numb;
  // scheduler results
  logic [WAYS-1:0]       way_fire_c;
  logic [NUM_RS-1:0]     rs_push_c;
  logic [2*NUM_RS-1:0]   rs_way_sel_c;
  logic                  dispatch_stop_c;
  logic [7:0]            stall_cycles;

  // Scheduler view
  modport slave (
    input  dispatch_flash, group_valid, way_valid, way_class, way_write,
    input  rs_full, rob_free_numb, free_reg_numb,
    output way_fire_c, rs_push_c, rs_way_sel_c, dispatch_stop_c, stall_cycles
  );

  // Decode / environment view
  modport master (
    output dispatch_flash, group_valid, way_valid, way_class, way_write,
    output rs_full, rob_free_numb, free_reg_numb,
    input  way_fire_c, rs_push_c, rs_way_sel_c, dispatch_stop_c, stall_cycles
  );
endinterface

// File: rtl/dispatch_issue_sched.sv
// In-order issue scheduler: picks the dispatching prefix of a 4-wide decode
// group, binds each way to a reservation-station write port, checks ROB and
// free-list capacity, and holds decode until the whole group has left.
module dispatch_issue_sched (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  dispatch_issue_sched_if.slave  i_disp
);

  localparam int unsigned WAYS    = 4;
  localparam int unsigned CNT_W   = 7;
  localparam int unsigned NUM_RS  = 7;
  localparam int unsigned CLS_W   = 3;
  localparam int unsigned RS_W    = 3;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned ALU_W   = 3;
  localparam int unsigned STALL_W = 8;

  localparam logic [RS_W-1:0]    RS_ALU1   = RS_W'(0);
  localparam logic [RS_W-1:0]    RS_ALU2   = RS_W'(1);
  localparam logic [CLS_W-1:0]   CLS_ALU   = CLS_W'(0);
  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  // registered state
  logic [WAYS-1:0]    r_done_mask;
  logic               r_alu_rr;
  logic [STALL_W-1:0] r_stall_cycles;

  // combinational scheduling results
  logic [WAYS-1:0]    w_pending;
  logic [WAYS-1:0]    w_fire;
  logic [NUM_RS-1:0]  w_claim;
  logic [SEL_W-1:0]   w_sel_arr [NUM_RS];
  logic [ALU_W-1:0]   w_alu_fires;
  logic [WAYS-1:0]    w_left;
  logic               w_live;

  // per-way scratch for the in-order walk
  logic               w_blocked;
  logic [CNT_W-1:0]   w_rob_cnt;
  logic [CNT_W-1:0]   w_reg_cnt;
  logic [CLS_W-1:0]   w_cls;
  logic [RS_W-1:0]    w_rs_idx;
  logic [RS_W-1:0]    w_alu_pref;
  logic [RS_W-1:0]    w_alu_alt;
  logic               w_rs_ok;
  logic               w_need_rs;
  logic               w_rob_ok;
  logic               w_reg_ok;

  // Outputs are live only out of reset and when no flush is in progress.
  assign w_live = i_rst_n & ~i_disp.dispatch_flash;

  assign w_pending = i_disp.group_valid ? (i_disp.way_valid & ~r_done_mask) : '0;

  // ALU preference order follows the round-robin bit.
  assign w_alu_pref = r_alu_rr ? RS_ALU2 : RS_ALU1;
  assign w_alu_alt  = r_alu_rr ? RS_ALU1 : RS_ALU2;

  // Walk ways 0..3; the first pending way that cannot go blocks all later ones.
  always_comb begin
    w_fire      = '0;
    w_claim     = '0;
    w_alu_fires = '0;
    w_blocked   = 1'b0;
    w_rob_cnt   = '0;
    w_reg_cnt   = '0;
    w_cls       = '0;
    w_rs_idx    = '0;
    w_rs_ok     = 1'b0;
    w_need_rs   = 1'b0;
    w_rob_ok    = 1'b0;
    w_reg_ok    = 1'b0;
    for (int k = 0; k < int'(NUM_RS); k++) begin
      w_sel_arr[k] = '0;
    end

    if (w_live) begin
      for (int i = 0; i < int'(WAYS); i++) begin
        w_cls     = i_disp.way_class[i*CLS_W +: CLS_W];
        w_rs_idx  = '0;
        w_rs_ok   = 1'b0;
        w_need_rs = 1'b1;

        // RS binding by class
        if (w_cls == CLS_ALU) begin
          if (!i_disp.rs_full[w_alu_pref] && !w_claim[w_alu_pref]) begin
            w_rs_idx = w_alu_pref;
            w_rs_ok  = 1'b1;
          end else if (!i_disp.rs_full[w_alu_alt] && !w_claim[w_alu_alt]) begin
            w_rs_idx = w_alu_alt;
            w_rs_ok  = 1'b1;
          end
        end else if (w_cls <= CLS_W'(5)) begin
          // BRU..LSU map onto RS index class+1
          w_rs_idx = RS_W'(w_cls + CLS_W'(1));
          w_rs_ok  = !i_disp.rs_full[w_rs_idx] && !w_claim[w_rs_idx];
        end else begin
          w_need_rs = 1'b0;
          w_rs_ok   = 1'b1;
        end

        // capacity for this way on top of the lower firing ways
        w_rob_ok = (w_rob_cnt + CNT_W'(1)) <= i_disp.rob_free_numb;
        w_reg_ok = !i_disp.way_write[i] ||
                   ((w_reg_cnt + CNT_W'(1)) <= i_disp.free_reg_numb);

        if (w_pending[i] && !w_blocked) begin
          if (w_rs_ok && w_rob_ok && w_reg_ok) begin
            w_fire[i] = 1'b1;
            w_rob_cnt = w_rob_cnt + CNT_W'(1);
            if (i_disp.way_write[i]) begin
              w_reg_cnt = w_reg_cnt + CNT_W'(1);
            end
            if (w_need_rs) begin
              w_claim[w_rs_idx]   = 1'b1;
              w_sel_arr[w_rs_idx] = SEL_W'(i);
            end
            if (w_cls == CLS_ALU) begin
              w_alu_fires = w_alu_fires + ALU_W'(1);
            end
          end else begin
            w_blocked = 1'b1;
          end
        end
      end
    end
  end

  assign w_left = w_pending & ~w_fire;

  // Drive the combinational strobes onto the bus.
  always_comb begin
    i_disp.way_fire_c      = w_fire;
    i_disp.rs_push_c       = w_claim;
    i_disp.dispatch_stop_c = w_live & i_disp.group_valid & (|w_left);
    i_disp.rs_way_sel_c    = '0;
    for (int k = 0; k < int'(NUM_RS); k++) begin
      i_disp.rs_way_sel_c[k*SEL_W +: SEL_W] = w_sel_arr[k];
    end
  end

  assign i_disp.stall_cycles = r_stall_cycles;

  // Group progress, ALU round-robin and zero-progress perf counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_done_mask    <= '0;
      r_alu_rr       <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      if (i_disp.dispatch_flash) begin
        r_done_mask <= '0;
      end else if (i_disp.group_valid) begin
        r_done_mask <= (w_left == '0) ? '0 : (r_done_mask | w_fire);
      end

      if (!i_disp.dispatch_flash && (w_alu_fires == ALU_W'(1))) begin
        r_alu_rr <= ~r_alu_rr;
      end

      if (!i_disp.dispatch_flash && i_disp.group_valid && (|w_pending) &&
          (w_fire == '0) && (r_stall_cycles != STALL_MAX)) begin
        r_stall_cycles <= r_stall_cycles + STALL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dispatch_issue_sched.sv
// Directed bench for dispatch_issue_sched with hand-computed expectations.
module tb_dispatch_issue_sched;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  dispatch_issue_sched_if u_if ();

  dispatch_issue_sched u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_disp  (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] cls4(input logic [2:0] c3, input logic [2:0] c2,
                                       input logic [2:0] c1, input logic [2:0] c0);
    return {c3, c2, c1, c0};
  endfunction

  // Apply inputs and settle to mid-cycle for sampling.
  task automatic drive(input logic gv, input logic [3:0] wv, input logic [11:0] cls,
                       input logic [3:0] wr, input logic [6:0] full,
                       input logic [6:0] rob, input logic [6:0] regs, input logic flush);
    u_if.group_valid    = gv;
    u_if.way_valid      = wv;
    u_if.way_class      = cls;
    u_if.way_write      = wr;
    u_if.rs_full        = full;
    u_if.rob_free_numb  = rob;
    u_if.free_reg_numb  = regs;
    u_if.dispatch_flash = flush;
    #4;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] fire, input logic [6:0] push,
                            input logic [13:0] sel, input logic stop);
    chk({tag, ".fire"}, 32'(u_if.way_fire_c), 32'(fire));
    chk({tag, ".push"}, 32'(u_if.rs_push_c), 32'(push));
    chk({tag, ".sel"},  32'(u_if.rs_way_sel_c), 32'(sel));
    chk({tag, ".stop"}, 32'(u_if.dispatch_stop_c), 32'(stop));
  endtask

  initial begin
    logic [11:0] c_mix;
    logic [11:0] c_rob;
    logic [11:0] c_alu1;
    n_checks = 0;
    n_errors = 0;
    c_mix  = cls4(3'd4, 3'd5, 3'd1, 3'd0);
    c_rob  = cls4(3'd6, 3'd6, 3'd6, 3'd6);
    c_alu1 = cls4(3'd6, 3'd6, 3'd6, 3'd0);

    // reset forces outputs low even with a valid group present
    rst_n = 1'b0;
    drive(1'b1, 4'hF, c_mix, 4'hF, 7'd0, 7'd10, 7'd10, 1'b0);
    expect_out("rst", 4'h0, 7'h00, 14'h0000, 1'b0);
    chk("rst.stall", 32'(u_if.stall_cycles), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // full group ALU/BRU/LSU/MUL in one cycle (rr 0 -> 1)
    drive(1'b1, 4'hF, c_mix, 4'hF, 7'd0, 7'd10, 7'd10, 1'b0);
    expect_out("full", 4'hF, 7'b1100101, 14'h2C10, 1'b0);
    tick();

    // single ALU alternating with idle cycles
    drive(1'b1, 4'b0001, c_alu1, 4'h0, 7'd0, 7'd10, 7'd10, 1'b0);
    expect_out("alt1", 4'b0001, 7'b0000010, 14'h0000, 1'b0);  // rr 1 -> 0
    tick();
    drive(1'b0, 4'b0001, c_alu1, 4'h0, 7'd0, 7'd10, 7'd10, 1'b0);
    expect_out("idle1", 4'h0, 7'h00, 14'h0000, 1'b0);
    tick();
    drive(1'b1, 4'b0001, c_alu1, 4'h0, 7'd0, 7'd10, 7'd10, 1'b0);
    expect_out("alt2", 4'b0001, 7'b0000001, 14'h0000, 1'b0);  // rr 0 -> 1
    tick();
    drive(1'b0, 4'b0001, c_alu1, 4'h0, 7'd0, 7'd10, 7'd10, 1'b0);
    expect_out("idle2", 4'h0, 7'h00, 14'h0000, 1'b0);
    tick();
    drive(1'b1, 4'b0001, c_alu1, 4'h0, 7'd0, 7'd10, 7'd10, 1'b0);
    expect_out("alt3", 4'b0001, 7'b0000010, 14'h0000, 1'b0);  // rr 1 -> 0
    tick();
    drive(1'b1, 4'b0001, c_alu1, 4'h0, 7'b0000001, 7'd10, 7'd10, 1'b0);
    expect_out("alu1full", 4'b0001, 7'b0000010, 14'h0000, 1'b0);  // rr 0 -> 1
    tick();
    drive(1'b1, 4'b0001, c_alu1, 4'h0, 7'd0, 7'd10, 7'd10, 1'b0);
    expect_out("alt4", 4'b0001, 7'b0000010, 14'h0000, 1'b0);  // rr 1 -> 0
    tick();

    // three ALUs + LSU: two cycles
    drive(1'b1, 4'hF, cls4(3'd5, 3'd0, 3'd0, 3'd0), 4'h0, 7'd0, 7'd10, 7'd10, 1'b0);
    expect_out("alu3a", 4'b0011, 7'b0000011, 14'h0004, 1'b1);
    tick();
    drive(1'b1, 4'hF, cls4(3'd5, 3'd0, 3'd0, 3'd0), 4'h0, 7'd0, 7'd10, 7'd10, 1'b0);
    expect_out("alu3b", 4'b1100, 7'b1000001, 14'h3002, 1'b0);  // rr 0 -> 1
    tick();

    // done mask back to 0: way0 of a fresh group fires
    drive(1'b1, 4'b0001, cls4(3'd6, 3'd6, 3'd6, 3'd1), 4'h0, 7'd0, 7'd10, 7'd10, 1'b0);
    expect_out("fresh", 4'b0001, 7'b0000100, 14'h0000, 1'b0);
    tick();

    // ROB capacity limit 2 then 5 (rr 1: ALU -> Alu2, then rr -> 0)
    drive(1'b1, 4'hF, c_mix, 4'hF, 7'd0, 7'd2, 7'd10, 1'b0);
    expect_out("rob2", 4'b0011, 7'b0000110, 14'h0010, 1'b1);
    tick();
    drive(1'b1, 4'hF, c_mix, 4'hF, 7'd0, 7'd5, 7'd10, 1'b0);
    expect_out("rob5", 4'b1100, 7'b1100000, 14'h2C00, 1'b0);
    tick();

    // free-register limit: writes on ways 0 and 2, one free reg
    drive(1'b1, 4'hF, c_rob, 4'b0101, 7'd0, 7'd10, 7'd1, 1'b0);
    expect_out("reg1", 4'b0011, 7'h00, 14'h0000, 1'b1);
    tick();
    drive(1'b1, 4'hF, c_rob, 4'b0101, 7'd0, 7'd10, 7'd5, 1'b0);
    expect_out("reg5", 4'b1100, 7'h00, 14'h0000, 1'b0);
    chk("stall0", 32'(u_if.stall_cycles), 32'd0);
    tick();

    // RobFreeNumb=0: three zero-progress cycles
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'b0001, c_rob, 4'h0, 7'd0, 7'd0, 7'd10, 1'b0);
      expect_out("rob0", 4'h0, 7'h00, 14'h0000, 1'b1);
      tick();
    end
    drive(1'b1, 4'b0001, c_rob, 4'h0, 7'd0, 7'd1, 7'd10, 1'b0);
    chk("stall3", 32'(u_if.stall_cycles), 32'd3);
    expect_out("rob1", 4'b0001, 7'h00, 14'h0000, 1'b0);
    tick();

    // flush of a partially dispatched group
    drive(1'b1, 4'hF, c_rob, 4'h0, 7'd0, 7'd2, 7'd10, 1'b0);
    expect_out("part", 4'b0011, 7'h00, 14'h0000, 1'b1);
    tick();
    drive(1'b1, 4'hF, c_mix, 4'h0, 7'd0, 7'd10, 7'd10, 1'b1);
    expect_out("flush", 4'h0, 7'h00, 14'h0000, 1'b0);
    tick();
    drive(1'b1, 4'b0001, c_rob, 4'h0, 7'd0, 7'd10, 7'd10, 1'b0);
    expect_out("postflush", 4'b0001, 7'h00, 14'h0000, 1'b0);
    chk("flush.stall", 32'(u_if.stall_cycles), 32'd3);
    tick();

    // group with no valid ways completes immediately
    drive(1'b1, 4'h0, c_mix, 4'h0, 7'd0, 7'd10, 7'd10, 1'b0);
    expect_out("empty", 4'h0, 7'h00, 14'h0000, 1'b0);
    tick();

    // DIV blocked for 300 cycles, ALU behind it must wait
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 4'b0011, cls4(3'd6, 3'd6, 3'd0, 3'd3), 4'h0, 7'b0010000, 7'd10, 7'd10, 1'b0);
      chk("divblk.fire", 32'(u_if.way_fire_c), 32'd0);
      if (i == 0)   chk("divblk.stall0", 32'(u_if.stall_cycles), 32'd3);
      if (i == 100) chk("divblk.stall100", 32'(u_if.stall_cycles), 32'd103);
      tick();
    end
    drive(1'b1, 4'b0011, cls4(3'd6, 3'd6, 3'd0, 3'd3), 4'h0, 7'd0, 7'd10, 7'd10, 1'b0);
    chk("stall.sat", 32'(u_if.stall_cycles), 32'd255);
    expect_out("divgo", 4'b0011, 7'b0010001, 14'h0001, 1'b0);
    tick();

    // reset in the middle of a group
    drive(1'b1, 4'hF, c_rob, 4'h0, 7'd0, 7'd2, 7'd10, 1'b0);
    expect_out("midgrp", 4'b0011, 7'h00, 14'h0000, 1'b1);
    tick();
    drive(1'b1, 4'hF, c_rob, 4'h0, 7'd0, 7'd10, 7'd10, 1'b0);
    rst_n = 1'b0;
    #1;
    expect_out("midrst", 4'h0, 7'h00, 14'h0000, 1'b0);
    chk("midrst.stall", 32'(u_if.stall_cycles), 32'd0);
    tick();
    rst_n = 1'b1;
    drive(1'b1, 4'hF, c_rob, 4'h0, 7'd0, 7'd10, 7'd10, 1'b0);
    expect_out("replay", 4'hF, 7'h00, 14'h0000, 1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
